// File: rtl/bp_pkg.sv
// bp_pkg: shared types and constants for the branch resolve queue.
// Rev 1.0
`default_nettype none

package bp_pkg;

    localparam int BP_PC_W = 32;
    localparam int PC_INC  = 4;

    typedef struct packed {
        logic [BP_PC_W-1:0] pc;
        logic               pred_taken;
        logic [BP_PC_W-1:0] pred_target;
    } bp_entry_t;

endpackage

`default_nettype wire

// File: rtl/bp_fifo.sv
// bp_fifo: circular prediction buffer with separate occupancy count and single-cycle flush.
// Rev 1.0
`default_nettype none

module bp_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  bp_entry_t              push_data,
    output bp_entry_t              head,
    output logic                   head_valid,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    bp_entry_t          mem [DEPTH];
    logic [DEPTH-1:0]   valid;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign full       = (count == CNT_W'(DEPTH));
    assign empty      = (count == '0);
    assign head       = mem[rd_ptr];
    assign head_valid = valid[rd_ptr];

    // A pop frees the head slot, so a push into a full buffer is legal in the same cycle.
    assign do_pop  = pop & head_valid & ~flush;
    assign do_push = push & ~flush & (~full | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
            valid  <= '0;
        end else begin
            // Pop is applied before push so a full-queue push reuses the freed slot's valid bit.
            if (do_pop) begin
                rd_ptr        <= rd_ptr + PTR_W'(1);
                valid[rd_ptr] <= 1'b0;
            end
            if (do_push) begin
                wr_ptr        <= wr_ptr + PTR_W'(1);
                valid[wr_ptr] <= 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: tracks in-flight predictions and resolves the oldest against execute.
// Rev 1.0
`default_nettype none

module branch_resolve_queue
    import bp_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = BP_PC_W
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_push,
    input  logic [PC_W-1:0]        i_push_pc,
    input  logic                   i_push_pred_taken,
    input  logic [PC_W-1:0]        i_push_pred_target,
    input  logic                   i_resolve,
    input  logic                   i_is_branch,
    input  logic                   i_is_jump,
    input  logic                   i_cond_true,
    input  logic [PC_W-1:0]        i_calc_target,
    input  logic                   i_ext_flush,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_valid_update,
    output logic                   o_actual_taken,
    output logic [PC_W-1:0]        o_actual_target,
    output logic                   o_taken_flush,
    output logic [PC_W-1:0]        o_redirect_pc,
    output logic                   o_err_sticky
);

    bp_entry_t       push_entry;
    bp_entry_t       head;
    logic            head_valid;
    logic            fifo_full;
    logic [PC_W-1:0] head_pc;
    logic [PC_W-1:0] head_pred_target;
    logic            resolve_ok;
    logic            actual_taken;
    logic            mispredict;
    logic [PC_W-1:0] redirect;
    logic            fifo_flush;
    logic            fifo_pop;
    logic            overflow;
    logic            underflow;

    assign push_entry.pc          = BP_PC_W'(i_push_pc);
    assign push_entry.pred_taken  = i_push_pred_taken;
    assign push_entry.pred_target = BP_PC_W'(i_push_pred_target);

    assign head_pc          = PC_W'(head.pc);
    assign head_pred_target = PC_W'(head.pred_target);

    // Neither branch nor jump is treated as a not-taken branch.
    assign resolve_ok   = i_resolve & head_valid & ~i_ext_flush;
    assign actual_taken = i_is_jump | (i_is_branch & i_cond_true);
    assign mispredict   = (head.pred_taken != actual_taken)
                        | (actual_taken & (head_pred_target != i_calc_target));
    assign redirect     = actual_taken ? i_calc_target : head_pc + PC_W'(PC_INC);

    // A mispredict discards every younger entry, including a same-cycle wrong-path push.
    assign fifo_flush = i_ext_flush | (resolve_ok & mispredict);
    assign fifo_pop   = resolve_ok & ~mispredict;
    assign overflow   = i_push & fifo_full & ~fifo_pop & ~fifo_flush;
    assign underflow  = i_resolve & ~head_valid & ~i_ext_flush;

    bp_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (i_clk),
        .rst_n      (i_rst_n),
        .push       (i_push),
        .pop        (fifo_pop),
        .flush      (fifo_flush),
        .push_data  (push_entry),
        .head       (head),
        .head_valid (head_valid),
        .full       (fifo_full),
        .empty      (o_empty),
        .count      (o_count)
    );

    assign o_full = fifo_full;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid_update  <= 1'b0;
            o_actual_taken  <= 1'b0;
            o_actual_target <= '0;
            o_taken_flush   <= 1'b0;
            o_redirect_pc   <= '0;
            o_err_sticky    <= 1'b0;
        end else begin
            o_valid_update <= resolve_ok;
            o_actual_taken <= resolve_ok & actual_taken;
            o_taken_flush  <= resolve_ok & mispredict;
            if (resolve_ok) begin
                o_actual_target <= i_calc_target;
            end
            if (resolve_ok && mispredict) begin
                o_redirect_pc <= redirect;
            end
            if (overflow || underflow) begin
                o_err_sticky <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve_queue.sv
// tb_branch_resolve_queue: scoreboard bench for branch_resolve_queue (DEPTH=4, PC_W=32).
// Rev 1.0
`default_nettype none

module tb_branch_resolve_queue;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_push;
    logic [31:0] i_push_pc;
    logic        i_push_pred_taken;
    logic [31:0] i_push_pred_target;
    logic        i_resolve;
    logic        i_is_branch;
    logic        i_is_jump;
    logic        i_cond_true;
    logic [31:0] i_calc_target;
    logic        i_ext_flush;
    logic        o_full;
    logic        o_empty;
    logic [2:0]  o_count;
    logic        o_valid_update;
    logic        o_actual_taken;
    logic [31:0] o_actual_target;
    logic        o_taken_flush;
    logic [31:0] o_redirect_pc;
    logic        o_err_sticky;

    always #5 i_clk = ~i_clk;

    branch_resolve_queue #(.DEPTH(4), .PC_W(32)) dut (
        .i_clk              (i_clk),
        .i_rst_n            (i_rst_n),
        .i_push             (i_push),
        .i_push_pc          (i_push_pc),
        .i_push_pred_taken  (i_push_pred_taken),
        .i_push_pred_target (i_push_pred_target),
        .i_resolve          (i_resolve),
        .i_is_branch        (i_is_branch),
        .i_is_jump          (i_is_jump),
        .i_cond_true        (i_cond_true),
        .i_calc_target      (i_calc_target),
        .i_ext_flush        (i_ext_flush),
        .o_full             (o_full),
        .o_empty            (o_empty),
        .o_count            (o_count),
        .o_valid_update     (o_valid_update),
        .o_actual_taken     (o_actual_taken),
        .o_actual_target    (o_actual_target),
        .o_taken_flush      (o_taken_flush),
        .o_redirect_pc      (o_redirect_pc),
        .o_err_sticky       (o_err_sticky)
    );

    typedef struct packed {
        logic        p;
        logic [31:0] pc;
        logic        pt;
        logic [31:0] ptg;
        logic        r;
        logic        b;
        logic        j;
        logic        c;
        logic [31:0] calc;
        logic        x;
    } stim_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        pt;
        logic [31:0] ptg;
    } ent_t;

    typedef struct packed {
        logic        v;
        logic        tk;
        logic        fl;
        logic [31:0] tgt;
        logic [31:0] rd;
    } res_t;

    ent_t mq[$];
    res_t sb[$];
    logic err_m = 1'b0;
    int   errors = 0;
    int   checks = 0;

    function automatic stim_t sp(input logic [31:0] pc, input logic pt, input logic [31:0] ptg);
        stim_t s = '0;
        s.p = 1'b1; s.pc = pc; s.pt = pt; s.ptg = ptg;
        return s;
    endfunction

    function automatic stim_t sr(input logic b, input logic j, input logic c, input logic [31:0] calc);
        stim_t s = '0;
        s.r = 1'b1; s.b = b; s.j = j; s.c = c; s.calc = calc;
        return s;
    endfunction

    function automatic stim_t sx();
        stim_t s = '0;
        s.x = 1'b1;
        return s;
    endfunction

    task automatic set_idle();
        i_push = 0; i_push_pc = '0; i_push_pred_taken = 0; i_push_pred_target = '0;
        i_resolve = 0; i_is_branch = 0; i_is_jump = 0; i_cond_true = 0;
        i_calc_target = '0; i_ext_flush = 0;
    endtask

    // Drives one cycle, advances the reference queue and records the expected pulse outputs.
    task automatic drive(input stim_t s);
        res_t e = '0;
        ent_t h;
        logic act, mis;
        i_push = s.p; i_push_pc = s.pc; i_push_pred_taken = s.pt; i_push_pred_target = s.ptg;
        i_resolve = s.r; i_is_branch = s.b; i_is_jump = s.j; i_cond_true = s.c;
        i_calc_target = s.calc; i_ext_flush = s.x;
        if (s.x) begin
            mq.delete();
        end else if (s.r && mq.size() > 0) begin
            h   = mq[0];
            act = s.j | (s.b & s.c);
            mis = (h.pt != act) || (act && (h.ptg != s.calc));
            e.v = 1'b1; e.tk = act; e.fl = mis; e.tgt = s.calc;
            e.rd = act ? s.calc : h.pc + 32'd4;
            if (mis) begin
                mq.delete();
            end else begin
                void'(mq.pop_front());
                if (s.p) mq.push_back('{s.pc, s.pt, s.ptg});
            end
        end else begin
            if (s.r) err_m = 1'b1;
            if (s.p) begin
                if (mq.size() < 4) mq.push_back('{s.pc, s.pt, s.ptg});
                else err_m = 1'b1;
            end
        end
        sb.push_back(e);
        @(posedge i_clk);
        #1;
        set_idle();
    endtask

    task automatic test_reset();
        checks++;
        if ({o_valid_update, o_actual_taken, o_taken_flush, o_err_sticky, o_full} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got=%b required=00000",
                     {o_valid_update, o_actual_taken, o_taken_flush, o_err_sticky, o_full});
        end
        checks++;
        if (o_empty !== 1'b1 || o_count !== 3'd0) begin
            errors++;
            $display("FAIL reset_occupancy got empty=%b count=%0d required empty=1 count=0", o_empty, o_count);
        end
        checks++;
        if (o_actual_target !== 32'h0 || o_redirect_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_targets got tgt=%h redir=%h required 0", o_actual_target, o_redirect_pc);
        end
    endtask

    task automatic test_basic_resolve();
        stim_t st[$];
        res_t  e;
        st.push_back(sp(32'h100, 0, 32'h0));
        st.push_back(sr(1, 0, 0, 32'h180));
        st.push_back(sp(32'h200, 0, 32'h0));
        st.push_back(sr(1, 0, 1, 32'h240));
        st.push_back(sp(32'h300, 1, 32'h380));
        st.push_back(sr(0, 1, 0, 32'h390));
        st.push_back(sp(32'hFFFF_FFFC, 1, 32'h40));
        st.push_back(sr(1, 0, 0, 32'h40));
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]);
            e = sb.pop_front();
            checks++;
            if ({o_valid_update, o_actual_taken, o_taken_flush} !== {e.v, e.tk, e.fl}) begin
                errors++;
                $display("FAIL basic_pulses step=%0d got=%b required=%b", i,
                         {o_valid_update, o_actual_taken, o_taken_flush}, {e.v, e.tk, e.fl});
            end
            if (e.v) begin
                checks++;
                if (o_actual_target !== e.tgt) begin
                    errors++;
                    $display("FAIL basic_target step=%0d got=%h required=%h", i, o_actual_target, e.tgt);
                end
            end
            if (e.fl) begin
                checks++;
                if (o_redirect_pc !== e.rd) begin
                    errors++;
                    $display("FAIL basic_redirect step=%0d got=%h required=%h", i, o_redirect_pc, e.rd);
                end
            end
            checks++;
            if ({o_count, o_empty} !== {3'(mq.size()), mq.size() == 0}) begin
                errors++;
                $display("FAIL basic_count step=%0d got=%0d required=%0d", i, o_count, mq.size());
            end
            if (i == 1) begin
                checks++;
                if ({o_valid_update, o_actual_taken, o_taken_flush, o_empty} !== 4'b1001) begin
                    errors++;
                    $display("FAIL not_taken_const got=%b required=1001",
                             {o_valid_update, o_actual_taken, o_taken_flush, o_empty});
                end
            end
            if (i == 3 || i == 5 || i == 7) begin
                checks++;
                if (o_redirect_pc !== (i == 3 ? 32'h240 : (i == 5 ? 32'h390 : 32'h0))) begin
                    errors++;
                    $display("FAIL redirect_const step=%0d got=%h", i, o_redirect_pc);
                end
            end
        end
    endtask

    task automatic test_full_wrap();
        stim_t st[$];
        res_t  e;
        for (int k = 0; k < 4; k++)
            st.push_back(sp(32'h400 + 32'(4 * k), 1, 32'h440 + 32'(4 * k)));
        st.push_back(sp(32'h500, 1, 32'h540));
        for (int k = 0; k < 4; k++)
            st.push_back(sp(32'h600 + 32'(4 * k), 1, 32'h640 + 32'(4 * k))
                         | sr(0, 1, 0, 32'h440 + 32'(4 * k)));
        for (int k = 0; k < 4; k++)
            st.push_back(sr(0, 1, 0, 32'h640 + 32'(4 * k)));
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]);
            e = sb.pop_front();
            checks++;
            if ({o_valid_update, o_actual_taken, o_taken_flush} !== {e.v, e.tk, e.fl}) begin
                errors++;
                $display("FAIL full_pulses step=%0d got=%b required=%b", i,
                         {o_valid_update, o_actual_taken, o_taken_flush}, {e.v, e.tk, e.fl});
            end
            checks++;
            if ({o_full, o_empty, o_count} !== {mq.size() == 4, mq.size() == 0, 3'(mq.size())}) begin
                errors++;
                $display("FAIL full_occupancy step=%0d got full=%b empty=%b count=%0d required count=%0d",
                         i, o_full, o_empty, o_count, mq.size());
            end
            checks++;
            if (o_err_sticky !== err_m) begin
                errors++;
                $display("FAIL full_err step=%0d got=%b required=%b", i, o_err_sticky, err_m);
            end
            if (i == 4) begin
                checks++;
                if ({o_full, o_count, o_err_sticky} !== {1'b1, 3'd4, 1'b1}) begin
                    errors++;
                    $display("FAIL overflow_const got full=%b count=%0d err=%b required 1/4/1",
                             o_full, o_count, o_err_sticky);
                end
            end
        end
    endtask

    task automatic test_mispredict_flush();
        stim_t st[$];
        res_t  e;
        st.push_back(sp(32'h700, 0, 32'h0));
        st.push_back(sp(32'h704, 0, 32'h0));
        st.push_back(sp(32'h708, 0, 32'h0));
        st.push_back(sp(32'h70C, 0, 32'h0) | sr(1, 0, 1, 32'h7A0));
        st.push_back(sp(32'h720, 0, 32'h0));
        st.push_back(sx() | sr(1, 0, 0, 32'h0) | sp(32'h730, 0, 32'h0));
        st.push_back(sr(1, 0, 0, 32'h0));
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]);
            e = sb.pop_front();
            checks++;
            if ({o_valid_update, o_actual_taken, o_taken_flush} !== {e.v, e.tk, e.fl}) begin
                errors++;
                $display("FAIL flush_pulses step=%0d got=%b required=%b", i,
                         {o_valid_update, o_actual_taken, o_taken_flush}, {e.v, e.tk, e.fl});
            end
            if (e.fl) begin
                checks++;
                if (o_redirect_pc !== e.rd) begin
                    errors++;
                    $display("FAIL flush_redirect step=%0d got=%h required=%h", i, o_redirect_pc, e.rd);
                end
            end
            checks++;
            if ({o_empty, o_count} !== {mq.size() == 0, 3'(mq.size())}) begin
                errors++;
                $display("FAIL flush_count step=%0d got=%0d required=%0d", i, o_count, mq.size());
            end
            if (i == 3 || i == 5) begin
                checks++;
                if ({o_empty, o_count, o_valid_update} !== {1'b1, 3'd0, (i == 3)}) begin
                    errors++;
                    $display("FAIL flush_const step=%0d got empty=%b count=%0d vu=%b",
                             i, o_empty, o_count, o_valid_update);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        drive(sp(32'h900, 0, 32'h0));
        drive(sp(32'h904, 0, 32'h0));
        drive(sr(1, 0, 1, 32'h9A0));
        sb.delete();
        checks++;
        if (o_taken_flush !== 1'b1 || o_redirect_pc !== 32'h9A0) begin
            errors++;
            $display("FAIL prereset_pulse got flush=%b redir=%h required 1/000009a0", o_taken_flush, o_redirect_pc);
        end
        i_push = 1; i_push_pc = 32'hA00;
        #2 i_rst_n = 1'b0;
        #1;
        checks++;
        if ({o_valid_update, o_actual_taken, o_taken_flush, o_err_sticky, o_full, o_count} !== 8'b0
            || o_actual_target !== 32'h0 || o_redirect_pc !== 32'h0 || o_empty !== 1'b1) begin
            errors++;
            $display("FAIL async_reset got vu=%b fl=%b err=%b cnt=%0d tgt=%h redir=%h empty=%b",
                     o_valid_update, o_taken_flush, o_err_sticky, o_count, o_actual_target,
                     o_redirect_pc, o_empty);
        end
        @(posedge i_clk);
        #1;
        checks++;
        if ({o_valid_update, o_count, o_empty} !== {1'b0, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_hold got vu=%b cnt=%0d empty=%b", o_valid_update, o_count, o_empty);
        end
        set_idle();
        mq.delete();
        err_m = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        drive(sp(32'hB00, 0, 32'h0));
        drive(sr(1, 0, 0, 32'h0));
        e_check_after_reset: begin
            res_t e;
            void'(sb.pop_front());
            e = sb.pop_front();
            checks++;
            if ({o_valid_update, o_actual_taken, o_taken_flush, o_empty, o_err_sticky} !== {e.v, e.tk, e.fl, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL post_reset_resolve got=%b required=%b",
                         {o_valid_update, o_actual_taken, o_taken_flush, o_empty, o_err_sticky},
                         {e.v, e.tk, e.fl, 1'b1, 1'b0});
            end
        end
    endtask

    initial begin
        set_idle();
        i_rst_n = 1'b0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        test_reset();
        i_rst_n = 1'b1;
        @(negedge i_clk);
        test_basic_resolve();
        test_full_wrap();
        test_mispredict_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
In-flight prediction tracker between fetch and execute. Fetch pushes the prediction for each branch or jump; execute resolves the oldest entry against the real outcome. The block produces registered update and flush signals that drive the agree predictor: i_valid_update, i_actual_taken, i_actual_target and i_taken_flush. It also produces the fetch redirect PC. On a mispredict it flushes all younger wrong-path entries.

Parameters:
DEPTH, 4, number of in-flight control-flow entries; power of two, at least 2
PC_W, 32, PC and target width

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_push  in  1  fetch enqueues a prediction for a branch or jump
i_push_pc  in  PC_W  PC of the predicted instruction
i_push_pred_taken  in  1  predictor o_taken at fetch
i_push_pred_target  in  PC_W  predictor o_predicted_pc at fetch
i_resolve  in  1  execute resolves the oldest entry this cycle
i_is_branch  in  1  resolving instruction is a conditional branch
i_is_jump  in  1  resolving instruction is jal/jalr
i_cond_true  in  1  branch comparator result
i_calc_target  in  PC_W  target computed in execute
i_ext_flush  in  1  trap/exception flush; empties the queue
o_full  out  1  count == DEPTH
o_empty  out  1  count == 0
o_count  out  $clog2(DEPTH)+1  occupancy
o_valid_update  out  1  one-cycle pulse: predictor update valid
o_actual_taken  out  1  resolved direction
o_actual_target  out  PC_W  resolved target
o_taken_flush  out  1  one-cycle pulse: mispredict, flush pipeline
o_redirect_pc  out  PC_W  correct next PC when o_taken_flush=1
o_err_sticky  out  1  set on overflow push or underflow resolve; cleared only by reset

Behaviour:
- Reset values: all outputs 0, o_empty=1, pointers 0, all entry valid bits 0.
- Storage: circular buffer of {pc, pred_taken, pred_target}.
  - Write pointer wraps at DEPTH, read pointer wraps at DEPTH.
  - Count is tracked separately so that full and empty are unambiguous.
- Resolution is a combinational compare on the head entry when i_resolve=1 and the queue is not empty:
  - actual_taken = i_is_jump | (i_is_branch & i_cond_true).
  - mispredict = (pred_taken != actual_taken) | (actual_taken & pred_target != i_calc_target).
  - redirect = actual_taken ? i_calc_target : pc + 4 (mod 2^PC_W).
- Output latency: all result outputs are registered and valid exactly 1 cycle after the resolve cycle.
  - o_valid_update pulses for every valid resolve.
  - o_actual_target = i_calc_target.
  - o_taken_flush and o_redirect_pc are meaningful only on a mispredict.
  - Outside a pulse, all pulse outputs return to 0; target registers hold their last value.
- Queue update on a mispredicting resolve:
  - The queue empties on the next edge: rd_ptr=wr_ptr, count=0.
  - A push in the same cycle is discarded, because it is wrong-path.
- Queue update on a correct resolve: the head is popped.
  - A simultaneous push is accepted, including when the queue is full.
  - Count is unchanged when push and pop coincide.
- i_ext_flush takes priority over everything:
  - The queue empties.
  - Any resolve in the same cycle produces no outputs; the pulse registers are cleared.
  - Any push in the same cycle is dropped.
- Push while full without a pop: dropped, and o_err_sticky is set.
- Resolve while empty: ignored, with no output pulse, and o_err_sticky is set.
- If i_is_branch and i_is_jump are both 0 during a resolve, actual_taken=0 and the entry is treated as a branch.
- Reset asserted mid-operation: the queue is cleared and outputs are zeroed immediately (asynchronous); no pending pulse survives.

Decomposition:
- Package bp_pkg:
  - PC_W default
  - bp_entry_t struct {pc, pred_taken, pred_target}
  - PC_INC constant = 4
- Sub-module bp_fifo holds pointers, count, storage and flush-clear, with push/pop/flush ports.
- Compare, redirect and output registers stay in the top module.

Test Plan:
- Correct not-taken: push pc=0x100, pred_taken=0; resolve with is_branch=1, cond_true=0 -> next cycle valid_update=1, actual_taken=0, taken_flush=0; queue empty.
- Direction mispredict: push pc=0x200, pred_taken=0; resolve with cond_true=1, calc_target=0x240 -> taken_flush=1, redirect_pc=0x240, actual_target=0x240.
- Target mispredict on jump: push pc=0x300, pred_taken=1, pred_target=0x380; resolve with is_jump=1, calc_target=0x390 -> taken_flush=1, redirect_pc=0x390, actual_taken=1.
- Taken-predicted branch resolves not-taken at pc=0xFFFFFFFC -> redirect_pc=0x00000000 (wrap-around).
- Fill to DEPTH=4 -> o_full=1. Then:
  - Push only -> err_sticky=1, count stays 4.
  - Push with a correct resolve -> count stays 4, FIFO order preserved across pointer wrap.
- Three entries queued, mispredict on the head with a simultaneous push -> count=0, o_empty=1 next cycle.
  - Then i_ext_flush together with a resolve -> no valid_update pulse.
  - Async reset mid-stream -> all outputs 0 immediately.
